// File: rtl/sk_subtractor_pipe.sv
// Pipelined Sklansky prefix subtractor: diff = A - B - bin, bout = borrow-out, valid/ready with full stall.
// Define SK_SUB_OVF_EN to add the signed-overflow output ovf.
module sk_subtractor_pipe #(
    parameter int unsigned W     = 16,
    parameter int unsigned LOG2W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] diff,
    output logic         bout
`ifdef SK_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);

    logic                  en;
    logic [LOG2W:0][W-1:0] g_q, p_q, hp_q;
    logic [LOG2W:0]        c0_q, v_q;
    logic [LOG2W:1][W-1:0] g_d, p_d;
    logic [W-1:0]          nb, g0_d, p0_d, diff_d;
    logic                  c0_d, bout_d;
    logic                  unused_p;

    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Subtract as A + ~B + ~bin; the carry-in is folded into bit 0's generate.
    always_comb begin
        nb      = ~B;
        c0_d    = ~bin;
        p0_d    = A ^ nb;
        g0_d    = A & nb;
        g0_d[0] = (A[0] & nb[0]) | (c0_d & (A[0] | nb[0]));
    end

    for (genvar k = 1; k <= LOG2W; k++) begin : g_lvl
        for (genvar i = 0; i < W; i++) begin : g_bit
            if (((i >> (k - 1)) % 2) == 1) begin : g_comb
                localparam int unsigned J = ((i >> k) << k) + (1 << (k - 1)) - 1;
                assign g_d[k][i] = g_q[k-1][i] | (p_q[k-1][i] & g_q[k-1][J]);
                assign p_d[k][i] = p_q[k-1][i] & p_q[k-1][J];
            end else begin : g_pass
                assign g_d[k][i] = g_q[k-1][i];
                assign p_d[k][i] = p_q[k-1][i];
            end
        end
    end

    // Group propagate of the last level is never consumed.
    assign unused_p = ^p_q[LOG2W];

    assign diff_d = hp_q[LOG2W] ^ {g_q[LOG2W][W-2:0], c0_q[LOG2W]};
    assign bout_d = ~g_q[LOG2W][W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            g_q       <= '0;
            p_q       <= '0;
            hp_q      <= '0;
            c0_q      <= '0;
            v_q       <= '0;
            out_valid <= 1'b0;
            diff      <= '0;
            bout      <= 1'b0;
        end else if (en) begin
            g_q[0]  <= g0_d;
            p_q[0]  <= p0_d;
            hp_q[0] <= p0_d;
            c0_q[0] <= c0_d;
            v_q[0]  <= in_valid;
            for (int k = 1; k <= int'(LOG2W); k++) begin
                g_q[k]  <= g_d[k];
                p_q[k]  <= p_d[k];
                hp_q[k] <= hp_q[k-1];
                c0_q[k] <= c0_q[k-1];
                v_q[k]  <= v_q[k-1];
            end
            out_valid <= v_q[LOG2W];
            diff      <= diff_d;
            bout      <= bout_d;
        end
    end

`ifdef SK_SUB_OVF_EN
    logic [LOG2W:0] as_q, bs_q;

    // Operand sign bits ride alongside the prefix tree for the overflow term.
    always_ff @(posedge clk) begin
        if (rst) begin
            as_q <= '0;
            bs_q <= '0;
            ovf  <= 1'b0;
        end else if (en) begin
            as_q <= {as_q[LOG2W-1:0], A[W-1]};
            bs_q <= {bs_q[LOG2W-1:0], B[W-1]};
            ovf  <= (as_q[LOG2W] ^ bs_q[LOG2W]) & (as_q[LOG2W] ^ diff_d[W-1]);
        end
    end
`endif

endmodule

// File: tb/tb_sk_subtractor_pipe.sv
// Directed and randomized self-checking bench for sk_subtractor_pipe at W=16.
module tb_sk_subtractor_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A, B;
    logic        bin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        bout;
    logic        ovf;

    int errors = 0;
    int checks = 0;

    logic [15:0] sa[$];
    logic [15:0] sb[$];
    logic        sbin[$];
    logic [16:0] exq[$];

    sk_subtractor_pipe #(.W(16), .LOG2W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .A        (A),
        .B        (B),
        .bin      (bin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .bout     (bout)
`ifdef SK_SUB_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

`ifndef SK_SUB_OVF_EN
    assign ovf = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference result {bout, diff} from a 17-bit unsigned subtraction.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input logic bi);
        logic [16:0] r;
        r = {1'b0, a} - {1'b0, b} - {16'd0, bi};
        return r;
    endfunction

    // One beat through an idle pipe; checks latency and result.
    task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b, input logic bi,
                          input logic [15:0] exp_d, input logic exp_b, input logic exp_o);
        int lat;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        A = a; B = b; bin = bi;
        lat = 0;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            lat++;
        end while (!out_valid && lat < 12);
        chk({tag, "_lat"}, lat, 6);
        chk({tag, "_diff"}, diff, exp_d);
        chk({tag, "_bout"}, bout, exp_b);
`ifdef SK_SUB_OVF_EN
        chk({tag, "_ovf"}, ovf, exp_o);
`else
        if (exp_o) chk({tag, "_ovf_unused"}, ovf, 0);
`endif
    endtask

    // Streams the queued operands; mode 0 always ready, 1 stall window, 2 random handshakes.
    task automatic run(input int mode, input int max_cycles);
        int          idx;
        int          cyc;
        logic        hold_v;
        logic [15:0] hold_d;
        logic        hold_b;
        logic [16:0] e;
        idx = 0; cyc = 0; hold_v = 1'b0; hold_d = '0; hold_b = 1'b0;
        while ((idx < sa.size() || exq.size() > 0) && cyc < max_cycles) begin
            @(posedge clk); #1;
            cyc++;
            if (hold_v) begin
                chk("hold_diff", diff, hold_d);
                chk("hold_bout", bout, hold_b);
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = !(cyc >= 8 && cyc <= 10);
                default: out_ready = ($urandom_range(0, 3) != 0);
            endcase
            if (idx < sa.size()) begin
                in_valid = (mode != 2) || ($urandom_range(0, 3) != 0);
                A = sa[idx]; B = sb[idx]; bin = sbin[idx];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
            if (out_valid && out_ready) begin
                if (exq.size() == 0) begin
                    chk("extra_beat", 1, 0);
                end else begin
                    e = exq.pop_front();
                    chk("stream_diff", diff, e[15:0]);
                    chk("stream_bout", bout, e[16]);
                end
            end
            hold_v = out_valid && !out_ready;
            hold_d = diff;
            hold_b = bout;
            if (in_valid && in_ready) begin
                exq.push_back(model(A, B, bin));
                idx++;
            end
        end
        in_valid = 1'b0;
        chk("drain_left", exq.size(), 0);
        chk("sent_all", idx, sa.size());
        sa.delete(); sb.delete(); sbin.delete(); exq.delete();
    endtask

    initial begin
        logic seen;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; bin = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_diff", diff, 16'h0000);
        chk("rst_bout", bout, 0);
        chk("rst_in_ready", in_ready, 1);
        rst = 1'b0;

        single("basic", 16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0);
        single("zero_minus_one", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        single("borrow_in_only", 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);
        single("equal", 16'hA5A5, 16'hA5A5, 1'b0, 16'h0000, 1'b0, 1'b0);
        single("max_minus_zero", 16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        single("ovf_neg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
        single("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);

        // Back-to-back stream with a three-cycle sink stall.
        for (int i = 0; i < 9; i++) begin
            sa.push_back(16'(16'h1111 * (i + 1)));
            sb.push_back(16'(16'h0F0F * i));
            sbin.push_back(i[0]);
        end
        run(1, 100);

        // Reset with four beats in flight.
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; A = 16'(16'h4000 + i); B = 16'h0001; bin = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_diff", diff, 16'h0000);
        chk("midrst_in_ready", in_ready, 1);
        seen = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
            seen = seen | out_valid;
        end
        chk("midrst_no_stale", seen, 0);

        // Randomized operands and handshakes.
        for (int i = 0; i < 1500; i++) begin
            sa.push_back(16'($urandom));
            sb.push_back(16'($urandom));
            sbin.push_back(1'($urandom_range(0, 1)));
        end
        run(2, 20000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
